regfile: RTL and testbench
==========================

Name: regfile

Overview:
- Architectural register file with per-register rename tags for the Tomasulo core.
- Sits directly downstream of the reorder buffer. It consumes the ROB's registered commit stream (rd, value, reorder tag) and its flush pulse.
- Serves the decoder:
  - combinational operand/tag lookup for rs/rt;
  - rename of rd to the newly allocated ROB tag on issue.
- Tag 0 means "not renamed; value is architectural". ROB tags in use are 1..15.

Parameters:
- REG_NUM, 32, number of architectural registers (x0..x31)
- TAG_BITS, 4, reorder tag width; tag value 0 reserved as "no producer"

Ports:
- in_clk  input  1  system clock, all state updates on rising edge
- in_rst  input  1  synchronous active-high reset
- in_rdy  input  1  global enable; when low, all state holds
- in_flush_enable  input  1  misprediction flush from ROB
- in_decoder_rs  input  5  source register 1 index
- in_decoder_rt  input  5  source register 2 index
- out_decoder_rs_value  output  32  committed value of rs (or bypassed commit)
- out_decoder_rt_value  output  32  committed value of rt (or bypassed commit)
- out_decoder_rs_busy  output  1  rs has an outstanding producer
- out_decoder_rt_busy  output  1  rt has an outstanding producer
- out_decoder_rs_reorder  output  4  producer tag of rs (0 when not busy)
- out_decoder_rt_reorder  output  4  producer tag of rt (0 when not busy)
- in_decoder_rename_enable  input  1  issue of an instruction writing rd
- in_decoder_rename_rd  input  5  destination register
- in_decoder_rename_reorder  input  4  ROB tag allocated to it (the ROB tail)
- in_rob_commit_enable  input  1  commit valid
- in_rob_commit_rd  input  5  committed destination
- in_rob_commit_value  input  32  committed result
- in_rob_commit_reorder  input  4  tag of committing entry

Behaviour:
- State: value[0..31] (32b), tag[0..31] (4b).
- Reset: all values and tags 0. All outputs are combinational, so post-reset reads return value 0, busy 0, reorder 0.
- x0: reads always return value 0, busy 0, tag 0. Writes and renames targeting x0 are ignored.
- Read (combinational, per port p in {rs,rt}):
  - busy_p = (tag[p] != 0); reorder_p = tag[p]; value_p = value[p].
  - Commit bypass: if in_rob_commit_enable, commit_rd == p != 0 and commit_reorder == tag[p], then value_p = commit_value, busy_p = 0, reorder_p = 0.
  - Rename of the same cycle is not reflected in reads. The issuing instruction's own sources see pre-rename state.
- Sequential update, only when in_rdy = 1 and in_rst = 0:
  1. Commit (enable, rd != 0): value[rd] <= commit_value unconditionally. tag[rd] <= 0 only if tag[rd] == commit_reorder; a newer producer keeps its tag.
  2. Rename (enable, rd != 0, no flush): tag[rd] <= rename_reorder. This overrides the step 1 tag clear when commit and rename hit the same rd.
  3. Flush: all tags <= 0. The same-cycle commit value write still occurs. Same-cycle rename is discarded.
- in_rdy = 0: no writes, no tag changes. Reads remain live.
- Reset mid-operation: reset wins over commit, rename and flush in the same cycle.
- Latency: a commit is visible via bypass in the same cycle and via the array from the next cycle. A rename is visible from the next cycle.
- Tag equality compares all 4 bits. No wrap handling is needed because the ROB never reuses a tag while it is outstanding.

Test Plan:
- Reset, then read rs=5, rt=0 -> value 0, busy 0, reorder 0 on both ports.
- Rename x5->tag 3. Next cycle read rs=5 -> busy 1, reorder 3. Commit x5=0x0000_00AB tag 3 in that same cycle -> bypass value 0xAB, busy 0. Following cycle the array holds 0xAB with tag 0.
- Rename x7->tag 2, then x7->tag 4, then commit x7=0x11 tag 2 -> value[7] = 0x11, tag stays 4, read shows busy 1, reorder 4.
- Same cycle: commit x9=0x22 tag 6 (tag[9] = 6) and rename x9->tag 8 -> next cycle value 0x22, tag 8, busy 1.
- Tags on x1, x2, x3 pending. Flush asserted with commit x1=0x33 and rename x4->tag 5 -> next cycle all busy 0, value[1] = 0x33, tag[4] = 0.
- Rename and commit to x0 with value 0xFF, plus in_rdy = 0 while commit x6=0x44 -> x0 reads 0, not busy. value[6] unchanged and tag[6] unchanged while in_rdy is low.

Source files
------------

// File: rtl/regfile_if.sv
// regfile_if: decoder and ROB-side signals of the register file
interface regfile_if;
  logic        in_rdy;
  logic        in_flush_enable;
  logic [4:0]  in_decoder_rs;
  logic [4:0]  in_decoder_rt;
  logic [31:0] out_decoder_rs_value;
  logic [31:0] out_decoder_rt_value;
  logic        out_decoder_rs_busy;
  logic        out_decoder_rt_busy;
  logic [3:0]  out_decoder_rs_reorder;
  logic [3:0]  out_decoder_rt_reorder;
  logic        in_decoder_rename_enable;
  logic [4:0]  in_decoder_rename_rd;
  logic [3:0]  in_decoder_rename_reorder;
  logic        in_rob_commit_enable;
  logic [4:0]  in_rob_commit_rd;
  logic [31:0] in_rob_commit_value;
  logic [3:0]  in_rob_commit_reorder;
  modport slave (
    input  in_rdy, in_flush_enable, in_decoder_rs, in_decoder_rt,
    input  in_decoder_rename_enable, in_decoder_rename_rd, in_decoder_rename_reorder,
    input  in_rob_commit_enable, in_rob_commit_rd, in_rob_commit_value, in_rob_commit_reorder,
    output out_decoder_rs_value, out_decoder_rt_value, out_decoder_rs_busy, out_decoder_rt_busy,
    output out_decoder_rs_reorder, out_decoder_rt_reorder
  );
  modport master (
    output in_rdy, in_flush_enable, in_decoder_rs, in_decoder_rt,
    output in_decoder_rename_enable, in_decoder_rename_rd, in_decoder_rename_reorder,
    output in_rob_commit_enable, in_rob_commit_rd, in_rob_commit_value, in_rob_commit_reorder,
    input  out_decoder_rs_value, out_decoder_rt_value, out_decoder_rs_busy, out_decoder_rt_busy,
    input  out_decoder_rs_reorder, out_decoder_rt_reorder
  );
endinterface

// File: rtl/regfile.sv
// regfile: architectural registers with rename tags and same-cycle commit bypass
module regfile #(
  parameter int REG_NUM  = 32,
  parameter int TAG_BITS = 4
) (
  input logic in_clk,
  input logic in_rst,
  regfile_if.slave bus
);
  logic [31:0]         value [REG_NUM];
  logic [TAG_BITS-1:0] tag [REG_NUM];
  logic                rs_hit, rt_hit;
  logic [TAG_BITS-1:0] rs_tag, rt_tag;
  // operand lookup; a matching commit this cycle clears the dependency and supplies its value
  always_comb begin
    rs_hit = bus.in_rob_commit_enable && bus.in_rob_commit_rd == bus.in_decoder_rs &&
             bus.in_decoder_rs != 5'd0 && bus.in_rob_commit_reorder == tag[bus.in_decoder_rs];
    rt_hit = bus.in_rob_commit_enable && bus.in_rob_commit_rd == bus.in_decoder_rt &&
             bus.in_decoder_rt != 5'd0 && bus.in_rob_commit_reorder == tag[bus.in_decoder_rt];
    rs_tag = (bus.in_decoder_rs == 5'd0 || rs_hit) ? '0 : tag[bus.in_decoder_rs];
    rt_tag = (bus.in_decoder_rt == 5'd0 || rt_hit) ? '0 : tag[bus.in_decoder_rt];
    bus.out_decoder_rs_value   = bus.in_decoder_rs == 5'd0 ? 32'd0 :
                                 rs_hit ? bus.in_rob_commit_value : value[bus.in_decoder_rs];
    bus.out_decoder_rt_value   = bus.in_decoder_rt == 5'd0 ? 32'd0 :
                                 rt_hit ? bus.in_rob_commit_value : value[bus.in_decoder_rt];
    bus.out_decoder_rs_busy    = |rs_tag;
    bus.out_decoder_rt_busy    = |rt_tag;
    bus.out_decoder_rs_reorder = rs_tag;
    bus.out_decoder_rt_reorder = rt_tag;
  end
  // commit writes the value and retires a matching tag; rename then overrides; flush clears every tag
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        value[i] <= '0;
        tag[i]   <= '0;
      end
    end else if (bus.in_rdy) begin
      for (int i = 1; i < REG_NUM; i++) begin
        if (bus.in_rob_commit_enable && bus.in_rob_commit_rd == 5'(i)) begin
          value[i] <= bus.in_rob_commit_value;
          if (tag[i] == bus.in_rob_commit_reorder) tag[i] <= '0;
        end
        if (bus.in_decoder_rename_enable && bus.in_decoder_rename_rd == 5'(i) && !bus.in_flush_enable)
          tag[i] <= bus.in_decoder_rename_reorder;
        if (bus.in_flush_enable) tag[i] <= '0;
      end
    end
  end
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed vectors against a behavioural register-file model
module tb_regfile;
  logic clk = 1'b0;
  logic rst;
  logic on = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [31:0] m_val [32];
  logic [3:0]  m_tag [32];
  regfile_if bus ();
  regfile dut (.in_clk(clk), .in_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [36:0] mread(input logic [4:0] r);
    logic [31:0] v;
    logic [3:0] t;
    if (r == 0) return 37'd0;
    v = m_val[r];
    t = m_tag[r];
    if (bus.in_rob_commit_enable && bus.in_rob_commit_rd == r && bus.in_rob_commit_reorder == t) begin
      v = bus.in_rob_commit_value;
      t = 0;
    end
    return {t != 0, t, v};
  endfunction
  always @(posedge clk) begin
    logic [3:0] nt [32];
    if (rst) begin
      foreach (m_val[i]) begin m_val[i] = 0; m_tag[i] = 0; end
    end else if (bus.in_rdy) begin
      nt = m_tag;
      if (bus.in_rob_commit_enable && bus.in_rob_commit_rd != 0) begin
        m_val[bus.in_rob_commit_rd] = bus.in_rob_commit_value;
        if (m_tag[bus.in_rob_commit_rd] == bus.in_rob_commit_reorder) nt[bus.in_rob_commit_rd] = 0;
      end
      if (bus.in_decoder_rename_enable && bus.in_decoder_rename_rd != 0 && !bus.in_flush_enable)
        nt[bus.in_decoder_rename_rd] = bus.in_decoder_rename_reorder;
      if (bus.in_flush_enable) foreach (nt[i]) nt[i] = 0;
      m_tag = nt;
    end
  end
  always @(negedge clk) if (on) begin
    logic [36:0] es, et;
    es = mread(bus.in_decoder_rs);
    et = mread(bus.in_decoder_rt);
    check("cyc_rs", {bus.out_decoder_rs_busy, bus.out_decoder_rs_reorder, bus.out_decoder_rs_value}, es);
    check("cyc_rt", {bus.out_decoder_rt_busy, bus.out_decoder_rt_reorder, bus.out_decoder_rt_value}, et);
  end
  task automatic idle();
    bus.in_rdy = 1; bus.in_flush_enable = 0;
    bus.in_decoder_rename_enable = 0; bus.in_decoder_rename_rd = 0; bus.in_decoder_rename_reorder = 0;
    bus.in_rob_commit_enable = 0; bus.in_rob_commit_rd = 0; bus.in_rob_commit_value = 0; bus.in_rob_commit_reorder = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask
  task automatic rename(input logic [4:0] rd, input logic [3:0] t);
    bus.in_decoder_rename_enable = 1; bus.in_decoder_rename_rd = rd; bus.in_decoder_rename_reorder = t;
  endtask
  task automatic commit(input logic [4:0] rd, input logic [31:0] v, input logic [3:0] t);
    bus.in_rob_commit_enable = 1; bus.in_rob_commit_rd = rd; bus.in_rob_commit_value = v; bus.in_rob_commit_reorder = t;
  endtask
  task automatic rd_rs(input string n, input logic [31:0] v, input logic b, input logic [3:0] t);
    check({n, "_val"}, bus.out_decoder_rs_value, v);
    check({n, "_busy"}, 32'(bus.out_decoder_rs_busy), 32'(b));
    check({n, "_tag"}, 32'(bus.out_decoder_rs_reorder), 32'(t));
  endtask
  task automatic rd_rt(input string n, input logic [31:0] v, input logic b, input logic [3:0] t);
    check({n, "_val"}, bus.out_decoder_rt_value, v);
    check({n, "_busy"}, 32'(bus.out_decoder_rt_busy), 32'(b));
    check({n, "_tag"}, 32'(bus.out_decoder_rt_reorder), 32'(t));
  endtask
  initial begin
    rst = 1; idle(); bus.in_decoder_rs = 0; bus.in_decoder_rt = 0;
    tick(); tick();
    rst = 0; on = 1;
    bus.in_decoder_rs = 5; bus.in_decoder_rt = 0; #1;
    rd_rs("rst_rs", 0, 0, 0); rd_rt("rst_rt", 0, 0, 0);
    rename(5, 3); tick(); idle();
    #1; rd_rs("ren5", 0, 1, 3);
    commit(5, 32'hAB, 3); #1; rd_rs("byp5", 32'hAB, 0, 0);
    tick(); idle(); #1;
    rd_rs("arr5", 32'hAB, 0, 0);
    check("m_val5", m_val[5], 32'hAB); check("m_tag5", 32'(m_tag[5]), 0);
    rename(7, 2); tick(); rename(7, 4); tick(); idle(); commit(7, 32'h11, 2); tick(); idle();
    bus.in_decoder_rs = 7; #1; rd_rs("x7", 32'h11, 1, 4);
    check("m_tag7", 32'(m_tag[7]), 4);
    rename(9, 6); tick(); idle();
    commit(9, 32'h22, 6); rename(9, 8); tick(); idle();
    bus.in_decoder_rs = 9; #1; rd_rs("x9", 32'h22, 1, 8);
    rename(1, 1); tick(); rename(2, 7); tick(); rename(3, 9); tick(); idle();
    bus.in_decoder_rs = 2; bus.in_decoder_rt = 3; #1; rd_rs("pend2", 0, 1, 7); rd_rt("pend3", 0, 1, 9);
    bus.in_flush_enable = 1; commit(1, 32'h33, 12); rename(4, 5); tick(); idle();
    #1; rd_rs("fl2", 0, 0, 0); rd_rt("fl3", 0, 0, 0);
    bus.in_decoder_rs = 1; bus.in_decoder_rt = 4; #1; rd_rs("fl1", 32'h33, 0, 0); rd_rt("fl4", 0, 0, 0);
    check("m_tag4", 32'(m_tag[4]), 0);
    rename(0, 10); commit(0, 32'hFF, 0); tick(); idle();
    bus.in_decoder_rs = 0; #1; rd_rs("x0", 0, 0, 0);
    rename(6, 11); tick(); idle();
    bus.in_rdy = 0; commit(6, 32'h44, 11); bus.in_decoder_rs = 6; #1;
    rd_rs("stall_byp", 32'h44, 0, 0);
    tick(); idle(); bus.in_rdy = 0; #1;
    rd_rs("stall6", 0, 1, 11);
    bus.in_rdy = 1; rst = 1; commit(6, 32'h55, 11); rename(9, 13); bus.in_flush_enable = 1; tick(); idle(); rst = 0;
    bus.in_decoder_rt = 9; #1; rd_rs("rst6", 0, 0, 0); rd_rt("rst9", 0, 0, 0);
    tick();
    on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
